// File: rtl/idli_sqi_arb_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_arb_m
//
// Purpose:
//   Shares the SQI memory port between instruction fetch (FE) and load/store
//   (LS). In IDLE it picks one requester, then runs the whole SQI transaction
//   for it: command, address, dummy (reads only), data, end. Only one
//   transaction runs at a time and nothing is queued. LS normally wins. FE
//   wins once it has lost STARVE_MAX arbitrations in a row.
//
// Request/grant handshake:
//   A requester raises *_req with its address, direction and data, and holds
//   all of them stable until its *_gnt pulse. The arbiter samples them on the
//   clock edge where it leaves IDLE. *_gnt is high for exactly one cycle, the
//   first command cycle. From that cycle on, the requester may drop or change
//   its inputs.
//
// Ports:
//   i_arb_gck        clock, rising edge
//   i_arb_rst        asynchronous active-high reset
//   i_arb_fe_req     fetch read request
//   i_arb_fe_addr    fetch address
//   o_arb_fe_gnt     fetch grant pulse
//   i_arb_ls_req     load/store request
//   i_arb_ls_wr      load/store direction, 1 = write
//   i_arb_ls_addr    load/store address
//   i_arb_ls_wdata   load/store write data
//   o_arb_ls_gnt     load/store grant pulse
//   o_arb_cs         SQI chip select, active-low
//   o_arb_sio        nibble driven to memory
//   o_arb_sio_oe     o_arb_sio drives the bus
//   i_arb_sio        nibble from memory
//   o_arb_rdata      registered read nibble, MSB nibble first
//   o_arb_rdata_vld  o_arb_rdata valid this cycle
//   o_arb_owner      owner of current/last transaction, 0 = FE, 1 = LS
//   o_arb_done       one-cycle pulse in the END cycle
// -----------------------------------------------------------------------------
module idli_sqi_arb_m #(
    parameter int ADDR_W     = 16,
    parameter int DATA_NIB   = 4,
    parameter int DUMMY_CYC  = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                    i_arb_gck,
    input  logic                    i_arb_rst,
    input  logic                    i_arb_fe_req,
    input  logic [ADDR_W-1:0]       i_arb_fe_addr,
    output logic                    o_arb_fe_gnt,
    input  logic                    i_arb_ls_req,
    input  logic                    i_arb_ls_wr,
    input  logic [ADDR_W-1:0]       i_arb_ls_addr,
    input  logic [4*DATA_NIB-1:0]   i_arb_ls_wdata,
    output logic                    o_arb_ls_gnt,
    output logic                    o_arb_cs,
    output logic [3:0]              o_arb_sio,
    output logic                    o_arb_sio_oe,
    input  logic [3:0]              i_arb_sio,
    output logic [3:0]              o_arb_rdata,
    output logic                    o_arb_rdata_vld,
    output logic                    o_arb_owner,
    output logic                    o_arb_done
);

    localparam int ADDR_NIB = ADDR_W / 4;
    localparam int DATA_W   = 4 * DATA_NIB;
    localparam int CMD_NIB  = 2;

    // One nibble counter serves every phase, so it is sized for the longest one.
    localparam int MAX_AD   = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
    localparam int MAX_ADC  = (MAX_AD > DUMMY_CYC) ? MAX_AD : DUMMY_CYC;
    localparam int MAX_PH   = (MAX_ADC > CMD_NIB) ? MAX_ADC : CMD_NIB;
    localparam int CNT_W    = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam int STV_W    = $clog2(STARVE_MAX + 1);

    localparam logic [7:0] OP_RD = 8'h03;
    localparam logic [7:0] OP_WR = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [DATA_W-1:0]  wdata_q,  wdata_d;
    logic               wr_q,     wr_d;
    logic               owner_q,  owner_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               fe_gnt_q, fe_gnt_d;
    logic               ls_gnt_q, ls_gnt_d;
    logic [3:0]         rdata_q,  rdata_d;
    logic               rvld_q,   rvld_d;

    logic               fe_wins;
    logic [7:0]         opcode;

    // FE wins if LS is absent or FE has been starved out; otherwise LS wins.
    assign fe_wins = i_arb_fe_req &&
                     (!i_arb_ls_req || (starve_q == STV_W'(STARVE_MAX)));

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_arb_gck or posedge i_arb_rst) begin
        if (i_arb_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            owner_q  <= 1'b0;
            starve_q <= '0;
            fe_gnt_q <= 1'b0;
            ls_gnt_q <= 1'b0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            fe_gnt_q <= fe_gnt_d;
            ls_gnt_q <= ls_gnt_d;
            rdata_q  <= rdata_d;
            rvld_q   <= rvld_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: arbitration and phase sequencing
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        fe_gnt_d = 1'b0;
        ls_gnt_d = 1'b0;
        rdata_d  = rdata_q;
        rvld_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fe_wins) begin
                    addr_d   = i_arb_fe_addr;
                    wdata_d  = '0;
                    wr_d     = 1'b0;
                    owner_d  = 1'b0;
                    starve_d = '0;
                    fe_gnt_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_CMD;
                end else if (i_arb_ls_req) begin
                    addr_d   = i_arb_ls_addr;
                    wdata_d  = i_arb_ls_wdata;
                    wr_d     = i_arb_ls_wr;
                    owner_d  = 1'b1;
                    ls_gnt_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_CMD;
                    // FE lost this round; count it, saturating.
                    if (i_arb_fe_req && (starve_q != STV_W'(STARVE_MAX))) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end

            ST_CMD: begin
                if (cnt_q == CNT_W'(CMD_NIB - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ADDR: begin
                // The top nibble is always the one on the bus; shift it out.
                addr_d = addr_q << 4;
                if (cnt_q == CNT_W'(ADDR_NIB - 1)) begin
                    cnt_d   = '0;
                    state_d = (wr_q || (DUMMY_CYC == 0)) ? ST_DATA : ST_DUMMY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DUMMY: begin
                if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (wr_q) begin
                    wdata_d = wdata_q << 4;
                end else begin
                    rdata_d = i_arb_sio;
                    rvld_d  = 1'b1;
                end
                if (cnt_q == CNT_W'(DATA_NIB - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_END;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus outputs decoded from state, so reset releases CS with no clock edge.
    // -------------------------------------------------------------------------
    always_comb begin
        o_arb_cs     = 1'b1;
        o_arb_sio    = 4'h0;
        o_arb_sio_oe = 1'b0;
        opcode       = wr_q ? OP_WR : OP_RD;

        case (state_q)
            ST_CMD: begin
                o_arb_cs     = 1'b0;
                o_arb_sio_oe = 1'b1;
                o_arb_sio    = (cnt_q == '0) ? opcode[7:4] : opcode[3:0];
            end
            ST_ADDR: begin
                o_arb_cs     = 1'b0;
                o_arb_sio_oe = 1'b1;
                o_arb_sio    = addr_q[ADDR_W-1 -: 4];
            end
            ST_DUMMY: begin
                o_arb_cs = 1'b0;
            end
            ST_DATA: begin
                o_arb_cs = 1'b0;
                if (wr_q) begin
                    o_arb_sio_oe = 1'b1;
                    o_arb_sio    = wdata_q[DATA_W-1 -: 4];
                end
            end
            default: begin
                o_arb_cs = 1'b1;
            end
        endcase
    end

    assign o_arb_fe_gnt    = fe_gnt_q;
    assign o_arb_ls_gnt    = ls_gnt_q;
    assign o_arb_rdata     = rdata_q;
    assign o_arb_rdata_vld = rvld_q;
    assign o_arb_owner     = owner_q;
    assign o_arb_done      = (state_q == ST_END);

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
module tb_idli_sqi_arb_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fe_req = 1'b0;
    logic [15:0] fe_addr = '0;
    logic        fe_gnt;
    logic        ls_req = 1'b0;
    logic        ls_wr = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [15:0] ls_wdata = '0;
    logic        ls_gnt;
    logic        cs;
    logic [3:0]  sio;
    logic        sio_oe;
    logic [3:0]  sio_in = '0;
    logic [3:0]  rdata;
    logic        rdata_vld;
    logic        owner;
    logic        done;

    int total = 0;
    int bad = 0;
    int starve_m = 0;

    always #5 clk = ~clk;

    idli_sqi_arb_m dut (
        .i_arb_gck       (clk),
        .i_arb_rst       (rst),
        .i_arb_fe_req    (fe_req),
        .i_arb_fe_addr   (fe_addr),
        .o_arb_fe_gnt    (fe_gnt),
        .i_arb_ls_req    (ls_req),
        .i_arb_ls_wr     (ls_wr),
        .i_arb_ls_addr   (ls_addr),
        .i_arb_ls_wdata  (ls_wdata),
        .o_arb_ls_gnt    (ls_gnt),
        .o_arb_cs        (cs),
        .o_arb_sio       (sio),
        .o_arb_sio_oe    (sio_oe),
        .i_arb_sio       (sio_in),
        .o_arb_rdata     (rdata),
        .o_arb_rdata_vld (rdata_vld),
        .o_arb_owner     (owner),
        .o_arb_done      (done)
    );

    // Called at the falling edge of an IDLE cycle with requests already set up.
    // Predicts the winner from the arbitration rule, builds the expected bus
    // nibble list for that transaction and checks it cycle by cycle through
    // the following IDLE cycle. won reports the grant the DUT actually gave.
    task automatic observe_txn(input bit drop_winner, input int raise_ls_at,
                               input int abort_at, input bit use_pat,
                               input logic [15:0] pat, output bit won);
        bit          win_ls;
        bit          e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wd;
        logic [7:0]  op;
        logic [4:0]  exp_q[$];
        logic [3:0]  rd_q[$];
        logic [4:0]  e;
        logic [3:0]  r;
        logic [1:0]  e_gnt;
        bit          e_vld;
        int          d0;
        int          len;

        won = 1'b0;
        if (fe_req && (!ls_req || starve_m == 8)) begin
            win_ls = 1'b0; starve_m = 0;
            e_wr = 1'b0; e_addr = fe_addr; e_wd = '0;
        end else begin
            win_ls = 1'b1;
            if (fe_req && starve_m < 8) starve_m = starve_m + 1;
            e_wr = ls_wr; e_addr = ls_addr; e_wd = ls_wdata;
        end
        op = e_wr ? 8'h02 : 8'h03;
        exp_q = {};
        rd_q = {};
        exp_q.push_back({1'b1, op[7:4]});
        exp_q.push_back({1'b1, op[3:0]});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, e_addr[15-4*i -: 4]});
        if (!e_wr) begin
            exp_q.push_back(5'h00);
            exp_q.push_back(5'h00);
        end
        d0 = exp_q.size();
        for (int i = 0; i < 4; i++)
            exp_q.push_back(e_wr ? {1'b1, e_wd[15-4*i -: 4]} : 5'h00);
        exp_q.push_back(5'h00);
        len = exp_q.size();

        for (int t = 0; t <= len; t++) begin
            @(negedge clk);
            e = (t < len) ? exp_q[t] : 5'h00;
            total++;
            if ({sio_oe, sio} !== e) begin
                bad++; $display("FAIL bus t=%0d got oe/sio=%h exp=%h", t, {sio_oe, sio}, e);
            end
            total++;
            if (cs !== (t >= len - 1)) begin
                bad++; $display("FAIL cs t=%0d got=%b exp=%b", t, cs, (t >= len - 1));
            end
            e_gnt = (t == 0) ? (win_ls ? 2'b01 : 2'b10) : 2'b00;
            total++;
            if ({fe_gnt, ls_gnt} !== e_gnt) begin
                bad++; $display("FAIL gnt t=%0d got fe/ls=%b exp=%b", t, {fe_gnt, ls_gnt}, e_gnt);
            end
            if (t == 0) won = ls_gnt;
            total++;
            if (done !== (t == len - 1)) begin
                bad++; $display("FAIL done t=%0d got=%b exp=%b", t, done, (t == len - 1));
            end
            total++;
            if (owner !== win_ls) begin
                bad++; $display("FAIL owner t=%0d got=%b exp=%b", t, owner, win_ls);
            end
            e_vld = !e_wr && (t > d0) && (t <= d0 + 4);
            total++;
            if (rdata_vld !== e_vld) begin
                bad++; $display("FAIL rdata_vld t=%0d got=%b exp=%b", t, rdata_vld, e_vld);
            end
            if (e_vld && rd_q.size() > 0) begin
                r = rd_q.pop_front();
                total++;
                if (rdata !== r) begin
                    bad++; $display("FAIL rdata t=%0d got=%h exp=%h", t, rdata, r);
                end
            end

            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                total++;
                if (cs !== 1'b1) begin
                    bad++; $display("FAIL abort_cs got=%b exp=1", cs);
                end
                total++;
                if ({sio_oe, sio, fe_gnt, ls_gnt, done} !== 8'h00) begin
                    bad++; $display("FAIL abort_bus got=%h exp=00", {sio_oe, sio, fe_gnt, ls_gnt, done});
                end
                total++;
                if ({rdata, rdata_vld, owner} !== 6'h00) begin
                    bad++; $display("FAIL abort_regs got=%h exp=00", {rdata, rdata_vld, owner});
                end
                starve_m = 0;
                fe_req = 1'b0;
                ls_req = 1'b0;
                return;
            end

            // Memory side: known pattern on request, random otherwise.
            if (use_pat && t >= d0 && t < d0 + 4) sio_in = pat[15-4*(t-d0) -: 4];
            else sio_in = 4'($urandom_range(0, 15));
            if (!e_wr && t >= d0 && t < d0 + 4) rd_q.push_back(sio_in);

            // After the grant the winner may change its inputs freely.
            if (t == 0) begin
                if (win_ls) begin
                    ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
                    ls_wr = 1'($urandom_range(0, 1));
                    if (drop_winner) ls_req = 1'b0;
                end else begin
                    fe_addr = 16'($urandom);
                    if (drop_winner) fe_req = 1'b0;
                end
            end
            if (t == raise_ls_at) begin
                ls_req = 1'b1; ls_wr = 1'($urandom_range(0, 1));
                ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (cs !== 1'b1) begin
            bad++; $display("FAIL reset_cs got=%b exp=1", cs);
        end
        total++;
        if ({sio_oe, sio, fe_gnt, ls_gnt, done} !== 8'h00) begin
            bad++; $display("FAIL reset_bus got=%h exp=00", {sio_oe, sio, fe_gnt, ls_gnt, done});
        end
        total++;
        if ({rdata, rdata_vld, owner} !== 6'h00) begin
            bad++; $display("FAIL reset_regs got=%h exp=00", {rdata, rdata_vld, owner});
        end
        rst = 1'b0;
        starve_m = 0;
        @(negedge clk);
        total++;
        if ({cs, fe_gnt, ls_gnt} !== 3'b100) begin
            bad++; $display("FAIL reset_idle got=%b exp=100", {cs, fe_gnt, ls_gnt});
        end
    endtask

    task automatic test_fe_read();
        bit won;
        fe_req = 1'b1; fe_addr = 16'h1234;
        observe_txn(1'b1, -1, -1, 1'b1, 16'hA5F0, won);
    endtask

    task automatic test_ls_write();
        bit won;
        ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 16'hBEEF; ls_wdata = 16'hCAFE;
        observe_txn(1'b1, -1, -1, 1'b0, 16'h0, won);
    endtask

    task automatic test_starve();
        bit won;
        bit last_won;
        int first_fe;
        first_fe = -1;
        last_won = 1'b0;
        fe_req = 1'b1; fe_addr = 16'($urandom);
        ls_req = 1'b1; ls_wr = 1'($urandom_range(0, 1));
        ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
        for (int i = 0; i < 10; i++) begin
            observe_txn(1'b0, -1, -1, 1'b0, 16'h0, won);
            if (!won && first_fe < 0) first_fe = i;
            last_won = won;
        end
        fe_req = 1'b0; ls_req = 1'b0;
        total++;
        if (first_fe !== 8) begin
            bad++; $display("FAIL starve_fe_slot got=%0d exp=8", first_fe);
        end
        total++;
        if (last_won !== 1'b1) begin
            bad++; $display("FAIL starve_ls_after got=%b exp=1", last_won);
        end
    endtask

    task automatic test_wait_outside_idle();
        bit won;
        fe_req = 1'b1; fe_addr = 16'($urandom);
        observe_txn(1'b1, 9, -1, 1'b0, 16'h0, won);
        observe_txn(1'b1, -1, -1, 1'b0, 16'h0, won);
        total++;
        if (won !== 1'b1) begin
            bad++; $display("FAIL wait_ls_gnt got=%b exp=1", won);
        end
    endtask

    task automatic test_reset_mid();
        bit won;
        ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 16'($urandom); fe_req = 1'b0;
        observe_txn(1'b1, -1, 3, 1'b0, 16'h0, won);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 16'($urandom);
        observe_txn(1'b1, -1, -1, 1'b0, 16'h0, won);
    endtask

    task automatic test_back_to_back();
        bit won;
        int k;
        for (int i = 0; i < 20; i++) begin
            if (!fe_req && !ls_req) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                k = $urandom_range(1, 3);
                fe_req = k[0]; fe_addr = 16'($urandom);
                ls_req = k[1]; ls_wr = 1'($urandom_range(0, 1));
                ls_addr = 16'($urandom); ls_wdata = 16'($urandom);
            end
            observe_txn(1'($urandom_range(0, 1)), -1, -1, 1'b0, 16'h0, won);
        end
        fe_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fe_read();
        test_ls_write();
        test_starve();
        test_wait_outside_idle();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
